// File: rtl/arb_fairness_monitor.sv
// Arbiter fairness monitor: tracks per-requester wait time, grant events,
// starvation and protocol errors of an observed req/grant pair.
module arb_fairness_monitor #(
   parameter int unsigned NUM_REQS     = 4,
   parameter int unsigned STARVE_LIMIT = 32,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [NUM_REQS-1:0] req,
   input  logic [NUM_REQS-1:0] grant,
   input  logic [2:0]          sel,
   output logic [CNT_W-1:0]    grant_count,
   output logic [CNT_W-1:0]    max_wait,
   output logic [NUM_REQS-1:0] starve,
   output logic                onehot_err,
   output logic                spurious_err,
   output logic                irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_GRANTED = 2'd2
   } state_e;

   state_e              state_q [NUM_REQS];
   state_e              state_d [NUM_REQS];
   logic [CNT_W-1:0]    wait_q  [NUM_REQS];
   logic [CNT_W-1:0]    wait_d  [NUM_REQS];
   logic [CNT_W-1:0]    max_q   [NUM_REQS];
   logic [CNT_W-1:0]    max_d   [NUM_REQS];
   logic [CNT_W-1:0]    gcnt_q  [NUM_REQS];
   logic [CNT_W-1:0]    gcnt_d  [NUM_REQS];
   logic [NUM_REQS-1:0] starve_q, starve_d;
   logic [NUM_REQS-1:0] gprev_q, gprev_d;
   logic [NUM_REQS-1:0] gevt_c;
   logic                onehot_q, onehot_d;
   logic                spur_q, spur_d;

   // Next-state: per-requester FSM, wait/max/grant counters, sticky flags; clear wins over events
   always_comb begin
      gevt_c   = grant & ~gprev_q;
      gprev_d  = grant;
      onehot_d = onehot_q | ((grant & (grant - NUM_REQS'(1))) != '0);
      spur_d   = spur_q | ((gevt_c & ~req) != '0);
      starve_d = starve_q;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         state_d[i] = state_q[i];
         wait_d[i]  = '0;
         max_d[i]   = max_q[i];
         gcnt_d[i]  = gcnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (grant[i])    state_d[i] = ST_GRANTED;
               else if (req[i]) state_d[i] = ST_WAIT;
            end
            ST_WAIT: begin
               if (grant[i])     state_d[i] = ST_GRANTED;
               else if (!req[i]) state_d[i] = ST_IDLE;
            end
            ST_GRANTED: begin
               if (!grant[i]) state_d[i] = req[i] ? ST_WAIT : ST_IDLE;
            end
            default: state_d[i] = ST_IDLE;
         endcase
         // Counter is already zero on entry, so one saturating increment covers enter and stay
         if (state_d[i] == ST_WAIT)
            wait_d[i] = (wait_q[i] == CNT_MAX) ? wait_q[i] : wait_q[i] + CNT_W'(1);
         // Compare the registered count so the final value is captured on the exit cycle
         if (wait_q[i] > max_q[i])
            max_d[i] = wait_q[i];
         if (wait_q[i] >= CNT_W'(STARVE_LIMIT))
            starve_d[i] = 1'b1;
         if (gevt_c[i] && (gcnt_q[i] != CNT_MAX))
            gcnt_d[i] = gcnt_q[i] + CNT_W'(1);
      end
      if (clear) begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            state_d[i] = ST_IDLE;
            wait_d[i]  = '0;
            max_d[i]   = '0;
            gcnt_d[i]  = '0;
         end
         starve_d = '0;
         onehot_d = 1'b0;
         spur_d   = 1'b0;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            state_q[i] <= ST_IDLE;
            wait_q[i]  <= '0;
            max_q[i]   <= '0;
            gcnt_q[i]  <= '0;
         end
         starve_q <= '0;
         gprev_q  <= '0;
         onehot_q <= 1'b0;
         spur_q   <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            state_q[i] <= state_d[i];
            wait_q[i]  <= wait_d[i];
            max_q[i]   <= max_d[i];
            gcnt_q[i]  <= gcnt_d[i];
         end
         starve_q <= starve_d;
         gprev_q  <= gprev_d;
         onehot_q <= onehot_d;
         spur_q   <= spur_d;
      end
   end

   // Readout mux over registered statistics; out-of-range sel reads zero
   always_comb begin
      grant_count = '0;
      max_wait    = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         if (32'(sel) == i) begin
            grant_count = gcnt_q[i];
            max_wait    = max_q[i];
         end
      end
   end

   assign starve       = starve_q;
   assign onehot_err   = onehot_q;
   assign spurious_err = spur_q;
   assign irq          = (|starve_q) | onehot_q | spur_q;

endmodule

// File: tb/tb_arb_fairness_monitor.sv
// Directed bench for arb_fairness_monitor with default parameters.
module tb_arb_fairness_monitor;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic [3:0]  req, grant;
   logic [2:0]  sel;
   logic [15:0] grant_count, max_wait;
   logic [3:0]  starve;
   logic        onehot_err, spurious_err, irq;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        rst;
      logic        clear;
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [2:0]  sel;
      logic [15:0] gc;
      logic [15:0] mw;
      logic [3:0]  st;
      logic        oh;
      logic        sp;
      logic        irq;
   } vec_t;

   vec_t vq[$];

   arb_fairness_monitor dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .req          (req),
      .grant        (grant),
      .sel          (sel),
      .grant_count  (grant_count),
      .max_wait     (max_wait),
      .starve       (starve),
      .onehot_err   (onehot_err),
      .spurious_err (spurious_err),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   // One clock, then sample 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] gc, input logic [15:0] mw,
                          input logic [3:0] st, input logic oh, input logic sp, input logic ir);
      chk({tag, ".grant_count"}, 32'(grant_count), 32'(gc));
      chk({tag, ".max_wait"},    32'(max_wait),    32'(mw));
      chk({tag, ".starve"},      32'(starve),      32'(st));
      chk({tag, ".onehot_err"},  32'(onehot_err),  32'(oh));
      chk({tag, ".spurious"},    32'(spurious_err), 32'(sp));
      chk({tag, ".irq"},         32'(irq),         32'(ir));
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; req = '0; grant = '0; sel = '0;

      //                rst clr req      grant    sel  gc  mw  st  oh sp irq
      vq.push_back('{1'b1,1'b0,4'b0000,4'b0000,3'd0,16'd0,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0000,3'd2,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd2,16'd1,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd2,16'd1,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd2,16'd1,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0100,4'b0100,3'd2,16'd2,16'd1,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0110,4'b0110,3'd1,16'd1,16'd0,4'b0,1'b1,1'b0,1'b1});
      vq.push_back('{1'b0,1'b0,4'b0000,4'b0000,3'd1,16'd1,16'd0,4'b0,1'b1,1'b0,1'b1});
      vq.push_back('{1'b0,1'b1,4'b0000,4'b0000,3'd1,16'd0,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0010,4'b0010,3'd1,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0000,4'b0010,3'd1,16'd1,16'd0,4'b0,1'b0,1'b0,1'b0});
      vq.push_back('{1'b0,1'b0,4'b0000,4'b1000,3'd3,16'd1,16'd0,4'b0,1'b0,1'b1,1'b1});
      vq.push_back('{1'b0,1'b0,4'b0000,4'b0000,3'd5,16'd0,16'd0,4'b0,1'b0,1'b1,1'b1});
      vq.push_back('{1'b1,1'b0,4'b0000,4'b0000,3'd3,16'd0,16'd0,4'b0,1'b0,1'b0,1'b0});

      foreach (vq[k]) begin
         rst = vq[k].rst; clear = vq[k].clear; req = vq[k].req;
         grant = vq[k].grant; sel = vq[k].sel;
         step();
         chk_all($sformatf("vec%0d", k), vq[k].gc, vq[k].mw, vq[k].st,
                 vq[k].oh, vq[k].sp, vq[k].irq);
      end

      // Starvation on requester 0 with limit 32
      rst = 1'b0; clear = 1'b0; req = 4'b0001; grant = '0; sel = 3'd0;
      for (int k = 1; k <= 40; k++) begin
         step();
         chk($sformatf("starve_c%0d", k), 32'(starve), (k >= 33) ? 32'd1 : 32'd0);
         chk($sformatf("starve_irq_c%0d", k), 32'(irq), (k >= 33) ? 32'd1 : 32'd0);
         chk($sformatf("starve_mw_c%0d", k), 32'(max_wait), 32'(k - 1));
      end
      grant = 4'b0001;
      step();
      chk_all("starve_grant", 16'd1, 16'd40, 4'b0001, 1'b0, 1'b0, 1'b1);
      req = '0; grant = '0;
      step();

      // Reset in the middle of a wait
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'b0010; sel = 3'd1;
      for (int k = 0; k < 10; k++) step();
      chk("midwait_mw_before", 32'(max_wait), 32'd9);
      rst = 1'b1;
      step();
      chk_all("midwait_rst", 16'd0, 16'd0, 4'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; req = '0;
      step();
      chk_all("midwait_after", 16'd0, 16'd0, 4'b0, 1'b0, 1'b0, 1'b0);

      // Wait counter saturation on requester 1
      req = 4'b0010; sel = 3'd1;
      for (int k = 0; k < 65541; k++) step();
      chk_all("sat_wait", 16'd0, 16'hFFFF, 4'b0010, 1'b0, 1'b0, 1'b1);
      grant = 4'b0010;
      step();
      chk_all("sat_grant", 16'd1, 16'hFFFF, 4'b0010, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_fairness_monitor.md
ARB_FAIRNESS_MONITOR -- requirements
Module: arb_fairness_monitor

Interface
REQ-001 Parameter NUM_REQS, default 4, number of requesters observed; legal values 2..8.
REQ-002 Parameter STARVE_LIMIT, default 32, wait cycles at which a requester is flagged starved; legal values 1..(2^CNT_W - 2).
REQ-003 Parameter CNT_W, default 16, width of every statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear of all statistics and sticky flags.
REQ-007 req  input  NUM_REQS  request vector, same signal that drives the arbiter.
REQ-008 grant  input  NUM_REQS  grant vector produced by the arbiter.
REQ-009 sel  input  3  requester index for the readout mux.
REQ-010 grant_count  output  CNT_W  grant events for requester sel.
REQ-011 max_wait  output  CNT_W  largest wait for requester sel.
REQ-012 starve  output  NUM_REQS  sticky per-requester starvation flags.
REQ-013 onehot_err  output  1  sticky: grant had more than one bit set.
REQ-014 spurious_err  output  1  sticky: grant bit set while its req was low at grant start.
REQ-015 irq  output  1  OR of starve bits, onehot_err and spurious_err.

Function
REQ-016 Each requester SHALL run a 3-state FSM: IDLE, WAIT, GRANTED.
REQ-017 IDLE -> WAIT when req[i]=1 and grant[i]=0; IDLE -> GRANTED when grant[i]=1.
REQ-018 WAIT -> GRANTED when grant[i]=1; WAIT -> IDLE when req[i]=0 and grant[i]=0 (request withdrawn).
REQ-019 GRANTED -> IDLE when grant[i]=0 and req[i]=0; GRANTED -> WAIT when grant[i]=0 and req[i]=1.
REQ-020 Wait counter i SHALL increment by 1 in each cycle in which the FSM is in WAIT or enters WAIT, and SHALL be zeroed on any transition out of WAIT.
REQ-021 Wait counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 max_wait[i] SHALL update to the wait counter value whenever that value exceeds it; it is compared every cycle, including the cycle the counter exits WAIT.
REQ-023 starve[i] SHALL set in the cycle after the wait counter reaches STARVE_LIMIT and remain set until rst or clear.
REQ-024 grant_count[i] SHALL increment once per grant event, defined as grant[i]=1 with grant[i]=0 in the previous cycle; held grants count once; saturates at 2^CNT_W-1.
REQ-025 onehot_err SHALL set in the cycle after any cycle with popcount(grant)>1.
REQ-026 spurious_err SHALL set in the cycle after a grant event for requester i with req[i]=0 in that same cycle; grant held after req drops SHALL NOT set it.
REQ-027 All statistics and flags SHALL be registered; latency from input cycle to visible output is exactly 1 clk.
REQ-028 grant_count and max_wait readout SHALL be a combinational mux of registered state indexed by sel; sel >= NUM_REQS returns 0.
REQ-029 irq SHALL be combinational OR of registered flags (no extra latency).
REQ-030 clear and an event in the same cycle: clear wins; the event is not recorded; FSMs return to IDLE.
REQ-031 Grant bits while req is X-free are the only inputs considered; no assumption on arbiter hold length.

Reset
REQ-032 rst=1 at a rising edge SHALL force all FSMs to IDLE, all counters and max_wait to 0, starve=0, onehot_err=0, spurious_err=0, irq=0.
REQ-033 rst SHALL take priority over clear and all events; reset mid-wait discards the partial wait with no max_wait update.
REQ-034 The previous-grant register used for edge detection SHALL reset to 0, so a grant asserted in the first cycle after reset counts as an event.

Verification
REQ-035 req=4'b0001 held, grant=0 for 40 cycles, STARVE_LIMIT=32 -> starve=4'b0001 and irq=1 from cycle 33; max_wait(sel=0)=40 after grant.
REQ-036 req[2]=1, grant[2]=1 for 4 cycles, low 1 cycle, high 4 cycles -> grant_count(sel=2)=2, no errors.
REQ-037 grant=4'b0110 for one cycle -> onehot_err=1 next cycle and held; clear pulse -> onehot_err=0 next cycle.
REQ-038 grant[3] rises with req[3]=0 -> spurious_err=1; separately req[1] drops while grant[1] held -> spurious_err stays 0.
REQ-039 Force 2^16+5 waiting cycles on req[1] -> max_wait(sel=1)=16'hFFFF, no wrap.
REQ-040 rst asserted mid-WAIT at wait count 10 -> all outputs 0 next cycle; sel=5 with NUM_REQS=4 -> grant_count=0, max_wait=0.
